multdiv_unit: RTL and testbench

//   Multicycle signed 32-bit multiply/divide unit in the execute stage, beside the
//   ALU (add/sub/and/or/shift). Takes the same operandA/operandB as the ALU.
//   Its result goes into the execute result mux ahead of the X/M latch.

---
 rtl/multdiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_multdiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit for the execute stage.
// Multiply is radix-2 Booth; divide is non-restoring on magnitudes with a sign fixup in DONE.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   operand_q;   // multiplicand for MULT, divisor magnitude for DIV
    logic [2*WIDTH:0]   prod_q;      // {accumulator, multiplier, booth guard bit}
    logic [WIDTH+1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic               neg_q;
    logic               div_zero_q;
    logic               div_ovf_q;

    logic start_mult, start_div, start, last_step;

    assign start_mult = ctrl_MULT & ~ctrl_DIV;
    assign start_div  = ctrl_DIV  & ~ctrl_MULT;
    assign start      = start_mult | start_div;
    assign last_step  = (cnt_q == CW'(WIDTH - 1));
    assign busy       = (state_q != S_IDLE);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (start_mult) begin
            state_d = S_MULT;
        end else if (start_div) begin
            state_d = S_DIV;
        end else begin
            case (state_q)
                S_MULT, S_DIV: if (last_step) state_d = S_DONE;
                S_DONE:        state_d = S_IDLE;
                default:       state_d = state_q;
            endcase
        end
    end

    // Booth step: add/subtract the multiplicand into a one-bit-wider accumulator,
    // then shift the whole register right arithmetically. The extra bit keeps
    // MIN_INT multiplicands from overflowing the partial sum.
    logic signed [WIDTH:0] booth_acc, booth_mcand, booth_sum;
    logic [2*WIDTH:0]      prod_next;

    always_comb begin
        booth_acc   = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        booth_mcand = {operand_q[WIDTH-1], operand_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = booth_acc + booth_mcand;
            2'b10:   booth_sum = booth_acc - booth_mcand;
            default: booth_sum = booth_acc;
        endcase
        prod_next = {booth_sum, prod_q[WIDTH:1]};
    end

    // Non-restoring step: the quotient bit is the sign of the new partial remainder.
    logic [WIDTH+1:0] rem_shift, div_ext, rem_next;
    logic [WIDTH-1:0] quot_next;

    always_comb begin
        rem_shift = {rem_q[WIDTH:0], quot_q[WIDTH-1]};
        div_ext   = {2'b00, operand_q};
        rem_next  = rem_q[WIDTH+1] ? (rem_shift + div_ext) : (rem_shift - div_ext);
        quot_next = {quot_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
    end

    // Final result formation, consumed only in DONE.
    logic [WIDTH:0]   prod_hi;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    always_comb begin
        prod_hi    = prod_q[2*WIDTH:WIDTH];
        fin_result = '0;
        fin_exc    = 1'b0;
        if (is_div_q) begin
            if (div_zero_q) begin
                fin_result = '0;
                fin_exc    = 1'b1;
            end else if (div_ovf_q) begin
                fin_result = MIN_INT;
                fin_exc    = 1'b1;
            end else begin
                fin_result = neg_q ? -quot_q : quot_q;
            end
        end else begin
            fin_result = prod_q[WIDTH:1];
            fin_exc    = ~((&prod_hi) | ~(|prod_hi));
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on a start
    // edge before being read, so only the control state and outputs need one.
    always_ff @(posedge clock) begin
        if (start) begin
            cnt_q    <= '0;
            is_div_q <= start_div;
            if (start_mult) begin
                operand_q <= data_operandA;
                prod_q    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            end else begin
                operand_q <= magnitude(data_operandB);
                quot_q    <= magnitude(data_operandA);
                rem_q     <= '0;
            end
            neg_q      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_q <= (data_operandB == '0);
            div_ovf_q  <= (data_operandA == MIN_INT) && (&data_operandB);
        end else begin
            case (state_q)
                S_MULT: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    rem_q  <= rem_next;
                    quot_q <= quot_next;
                    cnt_q  <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                data_result    <= '0;
                data_exception <= 1'b0;
            end else if (state_q == S_DONE) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
                data_resultRDY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes reference-model results,
// a monitor pops and compares on every data_resultRDY pulse.
module tb_multdiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [W-1:0]  data_operandA, data_operandB;
    logic          ctrl_MULT, ctrl_DIV;
    logic [W-1:0]  data_result;
    logic          data_exception, data_resultRDY, busy;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   rdy_count = 0;
    int   exp_rdy = 0;
    int   last_start = -1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic exp_t model(input bit is_div, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int due);
        exp_t   e;
        longint p;
        int     sa, sb;
        e.due = due;
        if (!is_div) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            if (sb == 0) begin
                e.res = '0;
                e.exc = 1'b1;
            end else if (sa == 32'sh80000000 && sb == -1) begin
                e.res = 32'h80000000;
                e.exc = 1'b1;
            end else begin
                e.res = 32'(sa / sb);
                e.exc = 1'b0;
            end
        end
        return e;
    endfunction

    // Monitor: every result pulse must match the oldest outstanding expectation.
    logic prev_rdy = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            edge_n++;
            #1;
            if (data_resultRDY) begin
                rdy_count++;
                check("rdy_width", 32'(prev_rdy), 32'd0);
                if (q.size() == 0) begin
                    check("spurious_rdy", 32'(data_resultRDY), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("result", data_result, e.res);
                    check("exception", 32'(data_exception), 32'(e.exc));
                    check("latency", 32'(edge_n), 32'(e.due));
                end
            end
            prev_rdy = data_resultRDY;
        end
    end

    // Called at a negedge; the start is sampled on the following rising edge.
    task automatic start_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        int e;
        e = edge_n + 1;
        if (q.size() != 0 && e <= last_start + W + 1) begin
            void'(q.pop_back());
            exp_rdy--;
        end
        q.push_back(model(is_div, a, b, e + W + 1));
        exp_rdy++;
        last_start    = e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic both_pulse();
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFFFFFF;
            2:       v = 32'h80000000;
            3:       v = 32'h1;
            4:       v = 32'($urandom_range(0, 200)) - 32'd100;
            5:       v = 32'($urandom_range(0, 65535)) - 32'd32768;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int base, gap;
        bit is_div;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", 32'(data_exception), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset in the middle of a multiply aborts it silently.
        start_op(1'b0, 32'd123, 32'd456);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        exp_rdy -= q.size();
        q.delete();
        last_start = -1000;
        @(negedge clock);
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", data_result, 32'd0);
        base = rdy_count;
        repeat (40) @(negedge clock);
        check("abort_no_rdy", 32'(rdy_count - base), 32'd0);

        // Directed multiplies and divides, including the exception corners.
        start_op(1'b0, 32'd7, -32'sd3);
        check("result_cleared", data_result, 32'd0);
        wait_drain();
        check("hold_result", data_result, 32'hFFFFFFEB);
        start_op(1'b0, 32'h00010000, 32'h00010000);  wait_drain();
        check("hold_exc", 32'(data_exception), 32'd1);
        start_op(1'b1, -32'sd7, 32'd2);               wait_drain();
        start_op(1'b1, 32'd100, 32'd0);               wait_drain();
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);   wait_drain();
        start_op(1'b0, 32'h80000000, 32'h80000000);   wait_drain();
        start_op(1'b1, 32'h80000000, 32'd1);          wait_drain();

        // A divide issued mid-multiply replaces it; one result only.
        base = rdy_count;
        start_op(1'b0, 32'd5, 32'd6);
        repeat (9) @(negedge clock);
        start_op(1'b1, 32'd20, 32'd4);
        wait_drain();
        check("restart_single_rdy", 32'(rdy_count - base), 32'd1);

        // Both controls together from idle are ignored.
        base = rdy_count;
        both_pulse();
        check("both_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clock);
        check("both_no_rdy", 32'(rdy_count - base), 32'd0);

        // Random operations with occasional restarts and ignored double starts.
        for (int i = 0; i < 2000; i++) begin
            is_div = 1'($urandom_range(0, 1));
            start_op(is_div, pick(), pick());
            case ($urandom_range(0, 19))
                0: gap = $urandom_range(0, 32);
                1: begin
                    repeat (5) @(negedge clock);
                    both_pulse();
                    gap = W + 1 - 6 + $urandom_range(0, 2);
                end
                default: gap = W + 1 + $urandom_range(0, 2);
            endcase
            repeat (gap) @(negedge clock);
        end
        wait_drain();
        check("rdy_per_start", 32'(rdy_count), 32'(exp_rdy));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
